tensor_core_operand_sequencer: RTL and testbench

Front/back-end stage wrapped around small_tensor_core. Accepts a byte stream of 32 signed operands (matrix A row-major, then matrix B row-major) over valid/ready and holds them in two 4x4 register arrays that drive the core inputs. Pulses the core's register-file write enable, then its start input, and waits for is_done_with_calculation. It then captures the 4x4 result and streams it out as 16 signed bytes over valid/ready.

---
 rtl/tensor_core_pkg.sv | 22 ++
 rtl/tensor_core_operand_sequencer.sv | 166 ++++++++++++++++
 tb/tb_tensor_core_operand_sequencer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_core_pkg.sv
// Shared types for the tensor-core operand sequencer and its neighbours.
//   DATA_WIDTH / DIM : element width and matrix dimension
//   elem_t           : one signed matrix element
//   matrix_t         : DIM x DIM array of elements, row-major, [row][col]
//   seq_state_t      : sequencer FSM states
package tensor_core_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DIM        = 4;

  typedef logic signed [DATA_WIDTH-1:0] elem_t;
  typedef elem_t [0:DIM-1][0:DIM-1]     matrix_t;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CLEAR = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } seq_state_t;

endpackage

// File: rtl/tensor_core_operand_sequencer.sv
// Operand/result sequencer around small_tensor_core.
// Collects 32 operand bytes (A row-major, then B row-major), holds them in
// register arrays that feed the core, pulses the core write enable and then
// start, waits for done (with timeout), captures the 4x4 result and streams
// it out as 16 bytes.
//
// Ports:
//   clock_in, reset_n             clock, async active-low reset
//   in_valid/in_ready/in_data     operand byte stream in
//   out_valid/out_ready/out_data  result byte stream out, out_last on [3][3]
//   busy                          high whenever not in LOAD
//   error                         sticky done-timeout flag, cleared by the
//                                 first operand byte of the next load
//   tc_write_enable, tc_start     core control pulses
//   tc_input1, tc_input2          matrices A and B to the core
//   tc_output, tc_done            core result and done flag
//   dbg_state                     current FSM state
//
// Handshake: a byte moves on a rising edge where valid && ready are both
// high. The source holds valid and data until that edge; ready/valid here
// are pure functions of the current state, never of the partner's signal.
module tensor_core_operand_sequencer
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DIM            = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clock_in,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         error,
  output logic                         tc_write_enable,
  output logic                         tc_start,
  output matrix_t                      tc_input1,
  output matrix_t                      tc_input2,
  input  matrix_t                      tc_output,
  input  logic                         tc_done,
  output seq_state_t                   dbg_state
);

  localparam int LOAD_LAST  = 2 * DIM * DIM - 1;
  localparam int DRAIN_LAST = DIM * DIM - 1;
  localparam int LW         = $clog2(2 * DIM * DIM);
  localparam int DW         = $clog2(DIM * DIM);
  localparam int TW         = $clog2(TIMEOUT_CYCLES);

  seq_state_t    state_q, state_d;
  logic [LW-1:0] load_idx_q, load_idx_d;
  logic [DW-1:0] drain_idx_q, drain_idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          error_q, error_d;
  matrix_t       a_q, a_d;
  matrix_t       b_q, b_d;
  matrix_t       res_q, res_d;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LOAD;
      load_idx_q  <= '0;
      drain_idx_q <= '0;
      timer_q     <= '0;
      error_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      load_idx_q  <= load_idx_d;
      drain_idx_q <= drain_idx_d;
      timer_q     <= timer_d;
      error_q     <= error_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    load_idx_d      = load_idx_q;
    drain_idx_d     = drain_idx_q;
    timer_d         = timer_q;
    error_d         = error_q;
    a_d             = a_q;
    b_d             = b_q;
    res_d           = res_q;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    out_last        = 1'b0;
    tc_write_enable = 1'b0;
    tc_start        = 1'b0;

    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Top index bit selects B; the low bits are row and column.
          if (load_idx_q[LW-1]) begin
            b_d[load_idx_q[3:2]][load_idx_q[1:0]] = in_data;
          end else begin
            a_d[load_idx_q[3:2]][load_idx_q[1:0]] = in_data;
          end
          if (load_idx_q == '0) error_d = 1'b0;
          if (load_idx_q == LW'(LOAD_LAST)) begin
            load_idx_d = '0;
            state_d    = CLEAR;
          end else begin
            load_idx_d = load_idx_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        tc_write_enable = 1'b1;
        state_d         = START;
      end
      START: begin
        tc_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (tc_done) begin
          res_d   = tc_output;
          timer_d = '0;
          state_d = DRAIN;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Result array is deliberately left as it was.
          error_d = 1'b1;
          timer_d = '0;
          state_d = LOAD;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (drain_idx_q == DW'(DRAIN_LAST));
        if (out_ready) begin
          if (drain_idx_q == DW'(DRAIN_LAST)) begin
            drain_idx_d = '0;
            state_d     = LOAD;
          end else begin
            drain_idx_d = drain_idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Forced to zero outside DRAIN so idle output is clean.
  assign out_data  = (state_q == DRAIN) ? res_q[drain_idx_q[3:2]][drain_idx_q[1:0]] : '0;
  assign busy      = (state_q != LOAD);
  assign error     = error_q;
  assign tc_input1 = a_q;
  assign tc_input2 = b_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tensor_core_operand_sequencer.sv
// Directed bench for tensor_core_operand_sequencer with a behavioural
// stand-in for small_tensor_core (fixed latency, wrapped 8-bit sums).
module tb_tensor_core_operand_sequencer;
  import tensor_core_pkg::*;

  localparam int CORE_LAT = 6;

  // ---------------- clock / reset ----------------
  logic clock_in = 1'b0;
  logic reset_n;
  always #5 clock_in = ~clock_in;

  logic              in_valid, in_ready, out_valid, out_ready, out_last;
  logic signed [7:0] in_data, out_data;
  logic              busy, error, tc_write_enable, tc_start, tc_done;
  matrix_t           tc_input1, tc_input2, tc_output;
  seq_state_t        dbg_state;

  tensor_core_operand_sequencer #(
    .DATA_WIDTH(8), .DIM(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clock_in(clock_in), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .error(error),
    .tc_write_enable(tc_write_enable), .tc_start(tc_start),
    .tc_input1(tc_input1), .tc_input2(tc_input2),
    .tc_output(tc_output), .tc_done(tc_done), .dbg_state(dbg_state)
  );

  // ---------------- core stand-in ----------------
  bit      done_en;
  logic    core_run, core_done;
  int      core_cnt;
  matrix_t core_out;

  function automatic matrix_t mat_mul(input matrix_t a, input matrix_t b);
    matrix_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
          int x, y;
          x = a[i][k];
          y = b[k][j];
          s += x * y;
        end
        r[i][j] = s[7:0];
      end
    return r;
  endfunction

  always @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      core_run <= 1'b0; core_cnt <= 0; core_done <= 1'b0; core_out <= '0;
    end else if (tc_write_enable) begin
      core_run <= 1'b0; core_cnt <= 0; core_done <= 1'b0;
    end else if (tc_start) begin
      core_run <= 1'b1; core_cnt <= 0;
    end else if (core_run) begin
      if (core_cnt == CORE_LAT - 1) begin
        core_run  <= 1'b0;
        core_done <= done_en;
        core_out  <= mat_mul(tc_input1, tc_input2);
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end
  assign tc_done   = core_done;
  assign tc_output = core_out;

  // ---------------- monitors ----------------
  int we_cnt = 0, st_cnt = 0, ov_cnt = 0, ready_bad = 0;
  always @(negedge clock_in) begin
    if (tc_write_enable) we_cnt++;
    if (tc_start) st_cnt++;
    if (out_valid) ov_cnt++;
    if (busy && in_ready) ready_bad++;
  end

  // ---------------- scoreboard ----------------
  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ops[32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers (enter and leave just after a negedge) ----------------
  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin
      @(negedge clock_in);
      n++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    @(negedge clock_in);
    in_valid = 1'b0;
  endtask

  task automatic load(input int from, input bit gaps);
    for (int i = from; i < 32; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clock_in);
      send_byte(ops[i]);
    end
  endtask

  task automatic drain_check(input int n, input bit stall);
    for (int k = 0; k < n; k++) begin
      int w;
      logic [7:0] e;
      e = exp_q.pop_front();
      w = 0;
      while (!out_valid && w < 500) begin
        @(negedge clock_in);
        w++;
      end
      check("out_valid_wait", out_valid, 1'b1);
      if (stall) begin
        int s;
        s = $urandom_range(0, 2);
        for (int j = 0; j < s; j++) begin
          @(negedge clock_in);
          check("stall_valid", out_valid, 1'b1);
          check_byte("stall_data", out_data, e);
          check("stall_last", out_last, (k == 15));
        end
      end
      check_byte("out_data", out_data, e);
      check("out_last", out_last, (k == 15));
      out_ready = 1'b1;
      @(negedge clock_in);
      out_ready = 1'b0;
    end
    if (n == 16) check("valid_drop", out_valid, 1'b0);
  endtask

  task automatic fill_identity_ab();
    for (int k = 0; k < 16; k++) begin
      ops[k]      = (k / 4 == k % 4) ? 8'd1 : 8'd0;
      ops[16 + k] = (k / 4 == k % 4) ? 8'd1 : 8'd0;
    end
  endtask

  task automatic push_identity();
    for (int k = 0; k < 16; k++) exp_q.push_back((k / 4 == k % 4) ? 8'd1 : 8'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int we0, st0, ov0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; done_en = 1'b1;

    // Reset values
    repeat (3) @(negedge clock_in);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check_byte("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_we", tc_write_enable, 1'b0);
    check("rst_start", tc_start, 1'b0);
    reset_n = 1'b1;
    @(negedge clock_in);
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_state", dbg_state, LOAD);

    // Identity x B(k) -> 0..15, one write-enable then one start pulse
    for (int k = 0; k < 16; k++) begin
      ops[k]      = (k / 4 == k % 4) ? 8'd1 : 8'd0;
      ops[16 + k] = 8'(k);
      exp_q.push_back(8'(k));
    end
    we0 = we_cnt; st0 = st_cnt;
    load(0, 1'b0);
    check("clear_we", tc_write_enable, 1'b1);
    check("clear_in_ready", in_ready, 1'b0);
    check("clear_start", tc_start, 1'b0);
    @(negedge clock_in);
    check("start_pulse", tc_start, 1'b1);
    check("start_we", tc_write_enable, 1'b0);
    check("start_in_ready", in_ready, 1'b0);
    drain_check(16, 1'b0);
    check("we_pulses", we_cnt - we0, 1);
    check("start_pulses", st_cnt - st0, 1);
    check_byte("a_hold", tc_input1[2][2], 8'd1);
    check_byte("b_hold", tc_input2[3][3], 8'd15);

    // All 5 x all 7 -> 140 wraps to -116
    for (int k = 0; k < 16; k++) begin
      ops[k] = 8'd5; ops[16 + k] = 8'd7;
      exp_q.push_back(8'h8C);
    end
    load(0, 1'b0);
    drain_check(16, 1'b0);

    // Identity x identity with input gaps and output stalls
    fill_identity_ab();
    push_identity();
    load(0, 1'b1);
    drain_check(16, 1'b1);

    // Done never arrives -> timeout
    done_en = 1'b0;
    ov0 = ov_cnt;
    load(0, 1'b0);
    repeat (2) @(negedge clock_in);
    check("wait_entry", dbg_state, WAIT);
    repeat (63) @(negedge clock_in);
    check("to_err_early", error, 1'b0);
    check("to_state_early", dbg_state, WAIT);
    @(negedge clock_in);
    check("to_error", error, 1'b1);
    check("to_state", dbg_state, LOAD);
    check("to_busy", busy, 1'b0);
    check("to_no_valid", ov_cnt - ov0, 0);
    done_en = 1'b1;
    send_byte(ops[0]);
    check("err_cleared", error, 1'b0);
    load(1, 1'b0);
    push_identity();
    drain_check(16, 1'b0);

    // Reset in the middle of draining
    load(0, 1'b0);
    push_identity();
    drain_check(8, 1'b0);
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_last", out_last, 1'b0);
    check_byte("mid_rst_data", out_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_we", tc_write_enable, 1'b0);
    check("mid_rst_start", tc_start, 1'b0);
    check("mid_rst_state", dbg_state, LOAD);
    @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);
    load(0, 1'b0);
    push_identity();
    drain_check(16, 1'b0);

    // Back-to-back transactions with different B
    for (int k = 0; k < 16; k++) begin
      ops[16 + k] = 8'(k + 16);
      exp_q.push_back(8'(k + 16));
    end
    load(0, 1'b0);
    drain_check(16, 1'b0);
    for (int k = 0; k < 16; k++) begin
      ops[16 + k] = 8'(100 - k);
      exp_q.push_back(8'(100 - k));
    end
    load(0, 1'b0);
    drain_check(16, 1'b0);
    check("in_ready_while_busy", ready_bad, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
